sig_deglitch: RTL and testbench

Input conditioning stage for IFC protocol test signals. It synchronises a raw asynchronous pin, rejects pulses shorter than a programmable qualification window, and drives a clean level plus single-cycle edge strobes into the edge-delay stage that follows it. It also counts rejected glitches so the test firmware can report link quality.

---
 rtl/sig_deglitch.sv | 125 ++++++++++++
 tb/tb_sig_deglitch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sig_deglitch.sv
// sig_deglitch: synchronise a raw pin, reject pulses shorter than filter_cycles+1 samples, emit a clean level with edge strobes.
// SIG_DEGLITCH_GLITCH_CNT_EN enables the saturating glitch counter and glitch_clr; without it glitch_cnt reads 0.
module sig_deglitch #(
    parameter int filter_cycles = 4,
    parameter int cnt_w         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_in,
    input  logic       glitch_clr,
    output logic       signal_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_cnt
);
    typedef enum logic [1:0] {LOW, RISE_QUAL, HIGH, FALL_QUAL} state_t;

    localparam logic [cnt_w-1:0] limit = cnt_w'(filter_cycles);

    state_t           state, state_nx;
    logic             s1, s2;
    logic [cnt_w-1:0] cnt, cnt_nx;
    logic             out_nx, rise_nx, fall_nx, glitch;

    // two-flop synchroniser; the FSM only ever looks at s2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= signal_in;
            s2 <= s1;
        end
    end

    // state, qualification counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOW;
            cnt        <= '0;
            signal_out <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            signal_out <= out_nx;
            rise_pulse <= rise_nx;
            fall_pulse <= fall_nx;
        end
    end

    // next state: a level must persist through the whole window, any reversal aborts as one glitch
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = signal_out;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        glitch   = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    state_nx = RISE_QUAL;
                    cnt_nx   = cnt_w'(1);
                end
            end
            RISE_QUAL: begin
                if (!s2) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                    glitch   = 1'b1;
                end else if (cnt == limit) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                    out_nx   = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + cnt_w'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nx = FALL_QUAL;
                    cnt_nx   = cnt_w'(1);
                end
            end
            default: begin
                if (s2) begin
                    state_nx = HIGH;
                    cnt_nx   = '0;
                    glitch   = 1'b1;
                end else if (cnt == limit) begin
                    state_nx = LOW;
                    cnt_nx   = '0;
                    out_nx   = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + cnt_w'(1);
                end
            end
        endcase
    end

`ifdef SIG_DEGLITCH_GLITCH_CNT_EN
    logic [7:0] gcnt;

    // saturating glitch counter; a clear beats a coincident glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gcnt <= 8'd0;
        else if (glitch_clr)
            gcnt <= 8'd0;
        else if (glitch && gcnt != 8'hff)
            gcnt <= gcnt + 8'd1;
    end

    assign glitch_cnt = gcnt;
`else
    logic unused_glitch;

    assign unused_glitch = glitch_clr ^ glitch;
    assign glitch_cnt    = 8'd0;
`endif
endmodule

// File: tb/tb_sig_deglitch.sv
// tb_sig_deglitch: directed checks of sig_deglitch with filter_cycles=4 in either build.
module tb_sig_deglitch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       signal_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       signal_out, rise_pulse, fall_pulse;
    logic [7:0] glitch_cnt;
    int         passed = 0;
    int         total = 0;
    int         rises = 0;
    int         falls = 0;
    int         both = 0;

    sig_deglitch #(.filter_cycles(4), .cnt_w(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .signal_in(signal_in),
        .glitch_clr(glitch_clr),
        .signal_out(signal_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise_pulse) rises++;
        if (fall_pulse) falls++;
        if (rise_pulse && fall_pulse) both++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int gexp(input int v);
`ifdef SIG_DEGLITCH_GLITCH_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic pulse2();
        signal_in = 1'b1;
        step(2);
        signal_in = 1'b0;
        step(2);
    endtask

    initial begin
        step(3);
        check("rst_out", signal_out, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_fall", fall_pulse, 0);
        check("rst_gcnt", glitch_cnt, 0);
        rst_n = 1'b1;
        step(20);
        check("idle_out", signal_out, 0);
        check("idle_strobes", rises + falls, 0);

        signal_in = 1'b1;
        step(6);
        check("rise_e5_out", signal_out, 0);
        step(1);
        check("rise_e6_out", signal_out, 1);
        check("rise_e6_pulse", rise_pulse, 1);
        step(1);
        check("rise_pulse_drop", rise_pulse, 0);
        check("rise_count", rises, 1);
        check("rise_gcnt", glitch_cnt, 0);

        signal_in = 1'b0;
        step(6);
        check("fall_e5_out", signal_out, 1);
        step(1);
        check("fall_e6_out", signal_out, 0);
        check("fall_e6_pulse", fall_pulse, 1);
        step(1);
        check("fall_count", falls, 1);

        signal_in = 1'b1;
        step(4);
        signal_in = 1'b0;
        step(10);
        check("short_out", signal_out, 0);
        check("short_rises", rises, 1);
        check("short_gcnt", glitch_cnt, gexp(1));

        signal_in = 1'b1;
        step(10);
        check("high_out", signal_out, 1);
        signal_in = 1'b0;
        step(1);
        signal_in = 1'b1;
        step(10);
        check("dip_out", signal_out, 1);
        check("dip_falls", falls, 1);
        check("dip_gcnt", glitch_cnt, gexp(2));

        signal_in = 1'b0;
        step(5);
        signal_in = 1'b1;
        step(12);
        check("b2b_out", signal_out, 1);
        check("b2b_falls", falls, 2);
        check("b2b_rises", rises, 3);
        check("b2b_gcnt", glitch_cnt, gexp(2));

        signal_in = 1'b0;
        step(10);
        for (int i = 0; i < 300; i++) pulse2();
        step(10);
        check("sat_out", signal_out, 0);
        check("sat_rises", rises, 3);
        check("sat_gcnt", glitch_cnt, gexp(255));

        signal_in = 1'b1;
        step(2);
        signal_in = 1'b0;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("clr_vs_glitch", glitch_cnt, 0);
        pulse2();
        step(6);
        check("after_clr_gcnt", glitch_cnt, gexp(1));

        signal_in = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check("midrst_out", signal_out, 0);
        check("midrst_rise", rise_pulse, 0);
        check("midrst_gcnt", glitch_cnt, 0);
        step(2);
        rst_n = 1'b1;
        step(6);
        check("post_rst_e5_out", signal_out, 0);
        step(1);
        check("post_rst_e6_out", signal_out, 1);
        check("post_rst_pulse", rise_pulse, 1);
        step(2);
        check("post_rst_rises", rises, 4);
        check("post_rst_gcnt", glitch_cnt, 0);
        check("no_dual_strobe", both, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
